spi_controller: RTL and testbench

SPI mode-0 initiator that drives the `spi_peripheral` register bank from the `m_clk` domain. It accepts one register-write request at a time over a valid/ready handshake. Each request is serialized as a 16-bit frame, MSB first, on `cs`/`s_clk`/`mosi`: bit 15 is the R/W flag, bits 14:8 the address, bits 7:0 the data. It sits beside the peripheral in on-chip loopback and is the bring-up source for configuration writes.

---
 rtl/spi_controller.sv | 215 +++++++++++++++++++++
 tb/tb_spi_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// spi_controller
//   SPI mode-0 initiator. Accepts one register-write request at a time over a
//   valid/ready handshake and shifts it out as a 16-bit frame, MSB first:
//   bit 15 = R/W flag, bits 14:8 = address, bits 7:0 = data.
//
// Parameters
//   CLK_DIV    : m_clk cycles per s_clk half-period (>= 2)
//   GAP_CYCLES : m_clk cycles cs stays high after a frame (>= 1)
//
// Ports
//   m_clk      in  : sole clock, rising edge
//   rst        in  : asynchronous active-high reset
//   req_valid  in  : request present
//   req_ready  out : idle and able to accept
//   req_write  in  : frame bit 15
//   req_addr   in  : frame bits 14:8
//   req_data   in  : frame bits 7:0
//   cs         out : chip select, active low
//   s_clk      out : SPI clock, idle low
//   mosi       out : serial data
//   frame_done out : one-cycle pulse when a frame completes
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       m_clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       cs,
  output logic       s_clk,
  output logic       mosi,
  output logic       frame_done
);

  localparam int HW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [HW-1:0] half_cnt;
  logic [GW-1:0] gap_cnt;
  logic [4:0]    bit_cnt;
  logic [4:0]    bit_cnt_next;
  logic [15:0]   shreg;
  logic [15:0]   shreg_next;

  logic accept;
  logic half_done;
  logic gap_done;

  logic cs_c;
  logic s_clk_c;
  logic mosi_c;
  logic frame_done_c;
  logic req_ready_c;

  assign accept    = req_valid & req_ready;
  assign half_done = (half_cnt == HW'(CLK_DIV - 1));
  assign gap_done  = (gap_cnt == GW'(GAP_CYCLES - 1));

  // State register.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: SETUP, then 16 HIGH/LOW pairs, then GAP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      SETUP: begin
        if (half_done) begin
          state_next = HIGH;
        end else begin
          state_next = SETUP;
        end
      end
      HIGH: begin
        if (half_done) begin
          state_next = LOW;
        end else begin
          state_next = HIGH;
        end
      end
      LOW: begin
        if (half_done && (bit_cnt == 5'd16)) begin
          state_next = GAP;
        end else if (half_done) begin
          state_next = HIGH;
        end else begin
          state_next = LOW;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_next = IDLE;
        end else begin
          state_next = GAP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift register and bit counter: load on accept, shift/count at the end of HIGH.
  always_comb begin
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    if (accept) begin
      shreg_next   = {req_write, req_addr, req_data};
      bit_cnt_next = 5'd0;
    end else if ((state == HIGH) && half_done) begin
      shreg_next   = {shreg[14:0], 1'b0};
      bit_cnt_next = bit_cnt + 5'd1;
    end else begin
      shreg_next   = shreg;
      bit_cnt_next = bit_cnt;
    end
  end

  // Datapath registers; the half-period counter reloads on every phase change.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      gap_cnt  <= '0;
      bit_cnt  <= 5'd0;
      shreg    <= 16'd0;
    end else begin
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      if (state_next != state) begin
        half_cnt <= '0;
      end else if ((state == SETUP) || (state == HIGH) || (state == LOW)) begin
        half_cnt <= half_cnt + HW'(1);
      end else begin
        half_cnt <= '0;
      end
      if ((state == GAP) && (state_next == GAP)) begin
        gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  // Output decode from the upcoming state so the registered pins change on the
  // same edge as the state register.
  always_comb begin
    cs_c         = 1'b1;
    s_clk_c      = 1'b0;
    mosi_c       = 1'b0;
    frame_done_c = 1'b0;
    req_ready_c  = 1'b0;
    case (state_next)
      IDLE: begin
        req_ready_c = 1'b1;
      end
      SETUP, LOW: begin
        cs_c   = 1'b0;
        mosi_c = shreg_next[15];
      end
      HIGH: begin
        cs_c    = 1'b0;
        s_clk_c = 1'b1;
        mosi_c  = shreg_next[15];
      end
      GAP: begin
        frame_done_c = (state == LOW);
      end
      default: begin
        cs_c = 1'b1;
      end
    endcase
  end

  // Output registers; reset forces cs high and s_clk low immediately.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      cs         <= 1'b1;
      s_clk      <= 1'b0;
      mosi       <= 1'b0;
      frame_done <= 1'b0;
      req_ready  <= 1'b0;
    end else begin
      cs         <= cs_c;
      s_clk      <= s_clk_c;
      mosi       <= mosi_c;
      frame_done <= frame_done_c;
      req_ready  <= req_ready_c;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller
//   Scoreboard bench for spi_controller (CLK_DIV=4, GAP_CYCLES=8). Accepted
//   requests are queued with their accept edge; a serial monitor decodes each
//   frame from cs/s_clk/mosi, checks content and timing, and feeds a small
//   5-register loopback bank.
module tb_spi_controller;
  localparam int D = 4;
  localparam int G = 8;

  logic       m_clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [6:0] req_addr = 7'd0;
  logic [7:0] req_data = 8'd0;
  logic       req_ready;
  logic       cs;
  logic       s_clk;
  logic       mosi;
  logic       frame_done;

  spi_controller #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
    .m_clk(m_clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .cs(cs), .s_clk(s_clk), .mosi(mosi), .frame_done(frame_done)
  );

  always #5 m_clk = ~m_clk;

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Edge index: value of cyc read right after posedge N is N.
  int cyc = 0;
  always @(posedge m_clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] frame;
    int          t;
  } exp_t;
  exp_t sb[$];

  logic [7:0] per_regs [5];
  int         done_cnt = 0;

  // Serial monitor and loopback register bank.
  initial begin
    int          now;
    int          rises;
    int          last_t;
    logic [15:0] sh;
    logic        in_frame;
    logic        prev_cs;
    logic        prev_sclk;
    logic        prev_ready;
    exp_t        e;
    rises = 0; last_t = -1; sh = 16'd0; in_frame = 1'b0;
    prev_cs = 1'b1; prev_sclk = 1'b0; prev_ready = 1'b0;
    for (int i = 0; i < 5; i++) per_regs[i] = 8'd0;
    forever begin
      @(negedge m_clk);
      now = cyc - 1;
      if (rst) begin
        if (in_frame) begin
          check_eq("trunc_edges", rises < 16, 1);
          if (sb.size() > 0) e = sb.pop_front();
        end
        in_frame = 1'b0;
        rises = 0;
        last_t = -1;
      end else begin
        if (frame_done) done_cnt++;
        if (prev_cs && !cs) begin
          in_frame = 1'b1;
          rises = 0;
          sh = 16'd0;
          if (sb.size() > 0) begin
            check_eq("cs_fall_t", now, sb[0].t);
            check_eq("mosi_msb", mosi, sb[0].frame[15]);
          end else begin
            check_eq("cs_fall_unexp", sb.size(), 1);
          end
        end
        if (!prev_sclk && s_clk) begin
          rises++;
          sh = {sh[14:0], mosi};
          check_eq("sclk_cs_low", cs, 0);
          if (rises == 1 && sb.size() > 0) check_eq("sclk_first_t", now, sb[0].t + D);
        end
        if (!prev_cs && cs && in_frame) begin
          in_frame = 1'b0;
          check_eq("edges", rises, 16);
          check_eq("done_pulse", frame_done, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("frame", sh, e.frame);
            check_eq("cs_rise_t", now, e.t + 33 * D);
            last_t = e.t;
          end
          if (rises == 16 && sh[15] && sh[14:8] < 7'd5) per_regs[sh[10:8]] = sh[7:0];
        end
        if (!prev_ready && req_ready && last_t >= 0) check_eq("ready_t", now, last_t + 33 * D + G);
      end
      prev_cs = cs;
      prev_sclk = s_clk;
      prev_ready = req_ready;
    end
  end

  // Present a request from a negedge and wait for its accept edge.
  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d, output int t_acc);
    int n;
    n = 0;
    t_acc = -1;
    req_write = w;
    req_addr = a;
    req_data = d;
    req_valid = 1'b1;
    while (t_acc < 0 && n < 2000) begin
      if (req_ready) begin
        @(posedge m_clk);
        t_acc = cyc;
        sb.push_back('{{w, a, d}, t_acc});
      end else begin
        @(negedge m_clk);
        n++;
      end
    end
    if (t_acc < 0) check_eq("accept_timeout", n, 0);
    @(negedge m_clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 5000) begin
      @(negedge m_clk);
      n++;
    end
    check_eq("idle_timeout", n < 5000, 1);
  endtask

  task automatic check_regs(input string tag, input logic [39:0] exp);
    for (int i = 0; i < 5; i++) check_eq(tag, per_regs[i], exp[8*i +: 8]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int t2;
    int n;
    // Reset state.
    repeat (3) @(negedge m_clk);
    check_eq("rst_cs", cs, 1);
    check_eq("rst_sclk", s_clk, 0);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_done", frame_done, 0);
    rst = 1'b0;
    #1 check_eq("ready_pre_edge", req_ready, 0);
    @(negedge m_clk);
    check_eq("ready_after_rst", req_ready, 1);

    // Single write 0x02/0xA5.
    send(1'b1, 7'h02, 8'hA5, t1);
    req_valid = 1'b0;
    wait_idle();

    // Two back-to-back requests with req_valid held.
    send(1'b1, 7'h01, 8'h3C, t1);
    send(1'b1, 7'h04, 8'hFF, t2);
    req_valid = 1'b0;
    check_eq("b2b_period", t2 - t1, 33 * D + G + 1);
    check_eq("b2b_cs_high", t2 - (t1 + 33 * D), G + 1);
    wait_idle();

    // Reset after the 5th rising s_clk.
    send(1'b1, 7'h03, 8'h77, t1);
    req_valid = 1'b0;
    n = 0;
    while (s_clk_rises_since(t1) < 5 && n < 1000) begin
      @(negedge m_clk);
      n++;
    end
    check_eq("abort_wait", n < 1000, 1);
    rst = 1'b1;
    #1;
    check_eq("abort_cs", cs, 1);
    check_eq("abort_sclk", s_clk, 0);
    repeat (3) @(negedge m_clk);
    check_eq("abort_ready", req_ready, 0);
    check_eq("abort_mosi", mosi, 0);
    rst = 1'b0;
    @(negedge m_clk);
    check_eq("abort_ready_rise", req_ready, 1);
    check_eq("abort_sb_empty", sb.size(), 0);
    check_regs("regs_after_abort", {8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h00});

    // Write 0x11..0x55 to addresses 0..4.
    for (int i = 0; i < 5; i++) send(1'b1, 7'(i), 8'(8'h11 * (i + 1)), t1);
    req_valid = 1'b0;
    wait_idle();
    check_regs("regs_fill", {8'h55, 8'h44, 8'h33, 8'h22, 8'h11});

    // Write to an absent address, then a read frame: nothing changes.
    send(1'b1, 7'h07, 8'h99, t1);
    send(1'b0, 7'h00, 8'hEE, t1);
    req_valid = 1'b0;
    wait_idle();
    check_regs("regs_unchanged", {8'h55, 8'h44, 8'h33, 8'h22, 8'h11});

    check_eq("done_count", done_cnt, 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Rising s_clk edges of the frame accepted at edge t, from the spec timing.
  function automatic int s_clk_rises_since(input int t);
    int k;
    k = cyc - 1 - t - D;
    if (k < 0) return 0;
    return k / (2 * D) + 1;
  endfunction

endmodule
